// File: rtl/regfile_pkg.sv
// Shared register-file widths, link offset and the writeback request payload.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;
  localparam logic [31:0] LINK_OFFSET = 32'd4;

  typedef struct packed {
    logic                 link;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic [31:0]          pc;
  } wb_req_t;

  // Return address of a JAL/JALR; wraps modulo 2^32.
  function automatic logic [31:0] link_value(input logic [31:0] pc);
    return pc + LINK_OFFSET;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus plus register-file write port.
// WB_SCOREBOARD_EN adds the issue/busy scoreboard signals.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = RF_DATA_W
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_link;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*32-1:0]         req_pc;
  logic                          wb_hold;
  logic                          rf_wen;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;

`ifdef WB_SCOREBOARD_EN
  logic                          iss_valid;
  logic [ADDR_WIDTH-1:0]         iss_rd;
  logic [(1<<ADDR_WIDTH)-1:0]    rd_busy;

  modport master (
    output req_valid, req_link, req_addr, req_data, req_pc, wb_hold, iss_valid, iss_rd,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, rd_busy
  );
  modport slave (
    input  req_valid, req_link, req_addr, req_data, req_pc, wb_hold, iss_valid, iss_rd,
    output req_ready, rf_wen, rf_waddr, rf_wdata, rd_busy
  );
`else
  modport master (
    output req_valid, req_link, req_addr, req_data, req_pc, wb_hold,
    input  req_ready, rf_wen, rf_waddr, rf_wdata
  );
  modport slave (
    input  req_valid, req_link, req_addr, req_data, req_pc, wb_hold,
    output req_ready, rf_wen, rf_waddr, rf_wdata
  );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first request at/after the pointer.
// Pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_c_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cand;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_c_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      idx = cand[PW-1:0];
      if (!found && en_i && req_i[idx]) begin
        found        = 1'b1;
        gnt_c_o[idx] = 1'b1;
        ptr_d        = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters; resolves
// link writes and filters x0. WB_SCOREBOARD_EN adds a per-register pending scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = RF_DATA_W
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t                req [NUM_REQ];
  wb_req_t                sel_c;
  logic [NUM_REQ-1:0]     gnt_c;
  logic                   grant_en_c;
  logic                   xfer_c;
  logic [DATA_WIDTH-1:0]  win_data_c;
  logic                   rf_wen_c;

  logic                   stg_vld_q, stg_vld_d;
  logic [ADDR_WIDTH-1:0]  stg_addr_q, stg_addr_d;
  logic [DATA_WIDTH-1:0]  stg_data_q, stg_data_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].link = bus.req_link[i];
      req[i].addr = RF_ADDR_W'(bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      req[i].data = RF_DATA_W'(bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]);
      req[i].pc   = bus.req_pc[i*32 +: 32];
    end
  end

  // The stage always drains when not held, so it can accept whenever hold is low.
  assign grant_en_c = rst_n & ~bus.wb_hold;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (bus.req_valid),
    .en_i    (grant_en_c),
    .gnt_c_o (gnt_c)
  );

  assign bus.req_ready = gnt_c;
  assign xfer_c        = |gnt_c;

  always_comb begin
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) sel_c = req[i];
    end
  end

  assign win_data_c = sel_c.link ? DATA_WIDTH'(link_value(sel_c.pc)) : DATA_WIDTH'(sel_c.data);

  // Output stage: load on transfer, empty on drain, freeze under hold.
  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_addr_d = stg_addr_q;
    stg_data_d = stg_data_q;
    if (xfer_c) begin
      stg_vld_d  = 1'b1;
      stg_addr_d = ADDR_WIDTH'(sel_c.addr);
      stg_data_d = win_data_c;
    end else if (!bus.wb_hold) begin
      stg_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
    end
  end

  assign rf_wen_c     = stg_vld_q & ~bus.wb_hold & (stg_addr_q != '0);
  assign bus.rf_wen   = rf_wen_c;
  assign bus.rf_waddr = stg_addr_q;
  assign bus.rf_wdata = stg_data_q;

`ifdef WB_SCOREBOARD_EN
  localparam int unsigned NREGS = 1 << ADDR_WIDTH;

  logic [1:0] cnt_q [NREGS];
  logic [1:0] cnt_d [NREGS];
  logic       inc_c, dec_c;

  // Saturating pending-write counters; simultaneous issue and drain cancel.
  always_comb begin
    inc_c = 1'b0;
    dec_c = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      inc_c    = bus.iss_valid && (bus.iss_rd == ADDR_WIDTH'(r)) && (r != 0);
      dec_c    = rf_wen_c && (stg_addr_q == ADDR_WIDTH'(r));
      if (inc_c && !dec_c && cnt_q[r] != 2'd3)      cnt_d[r] = cnt_q[r] + 2'd1;
      else if (dec_c && !inc_c && cnt_q[r] != 2'd0) cnt_d[r] = cnt_q[r] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= 2'd0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    bus.rd_busy = '0;
    for (int r = 0; r < NREGS; r++) bus.rd_busy[r] = (cnt_q[r] != 2'd0);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr;
  bit          m_vld;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt [32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n || bus.wb_hold) return -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_addr = '0; m_data = '0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  task automatic set_req(input int i, input bit v, input bit lk, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
    bus.req_valid[i]       = v;
    bus.req_link[i]        = lk;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
    bus.req_pc[i*32 +: 32]   = pc;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_link  = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int          g;
    bit          ew;
    logic [31:0] busy;
    logic [4:0]  ga;
    #1;
    if (!rst_n) model_reset();
    g = model_grant();
    check_eq("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    ew = rst_n && m_vld && !bus.wb_hold && (m_addr != 5'd0);
    check_eq("rf_wen", 64'(bus.rf_wen), 64'(ew));
    if (ew) begin
      check_eq("rf_waddr", 64'(bus.rf_waddr), 64'(m_addr));
      check_eq("rf_wdata", 64'(bus.rf_wdata), 64'(m_data));
    end
`ifdef WB_SCOREBOARD_EN
    busy = '0;
    for (int r = 0; r < 32; r++) busy[r] = (m_cnt[r] != 0);
    check_eq("rd_busy", 64'(bus.rd_busy), 64'(busy));
`endif
    @(posedge clk);
    if (rst_n) begin
`ifdef WB_SCOREBOARD_EN
      begin
        bit inc;
        inc = bus.iss_valid && (bus.iss_rd != 5'd0);
        if (!(inc && ew && bus.iss_rd == m_addr)) begin
          if (inc && m_cnt[bus.iss_rd] < 3) m_cnt[bus.iss_rd]++;
          if (ew && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
        end
      end
`endif
      if (g >= 0) begin
        ga     = bus.req_addr[g*AW +: AW];
        m_vld  = 1;
        m_addr = ga;
        m_data = bus.req_link[g] ? bus.req_pc[g*32 +: 32] + 32'd4 : bus.req_data[g*DW +: DW];
        m_ptr  = (g + 1) % NR;
      end else if (!bus.wb_hold) begin
        m_vld = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_wen", 64'(bus.rf_wen), 64'd0);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    check_eq("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_link = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_pc = '0; bus.wb_hold = 1'b0;
`ifdef WB_SCOREBOARD_EN
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with the stage full, then round-robin from requester 0.
    set_req(0, 1, 0, 5'd9, 32'h1234, 32'h0);
    cycle();
    set_req(0, 1, 0, 5'd1, 32'h11, 32'h0);
    set_req(1, 1, 0, 5'd2, 32'h22, 32'h0);
    set_req(2, 1, 0, 5'd3, 32'h33, 32'h0);
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      logic [2:0] rr_exp;
      rr_exp = 3'b001 << (n % 3);
      #1;
      check_eq("rr_grant", 64'(bus.req_ready), 64'(rr_exp));
      cycle();
    end

    // Link writes, including pc wrap.
    clear_reqs();
    set_req(1, 1, 1, 5'd1, 32'hFFFF_0000, 32'h8000_0010);
    cycle();
    clear_reqs();
    check_eq("link_wdata", 64'(bus.rf_wdata), 64'h8000_0014);
    check_eq("link_waddr", 64'(bus.rf_waddr), 64'd1);
    set_req(1, 1, 1, 5'd1, 32'h0, 32'hFFFF_FFFC);
    cycle();
    clear_reqs();
    check_eq("link_wrap", 64'(bus.rf_wdata), 64'd0);
    cycle();

    // x0 write accepted but never issued to the register file.
    set_req(0, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0);
    #1;
    check_eq("x0_ready", 64'(bus.req_ready), 64'd1);
    cycle();
    clear_reqs();
    check_eq("x0_wen", 64'(bus.rf_wen), 64'd0);
    set_req(0, 1, 0, 5'd4, 32'h4, 32'h0);
    set_req(1, 1, 0, 5'd6, 32'h6, 32'h0);
    set_req(2, 1, 0, 5'd8, 32'h8, 32'h0);
    #1;
    check_eq("x0_ptr", 64'(bus.req_ready), 64'd2);
    cycle();

    // Hold freezes the stage and blocks grants.
    clear_reqs();
    set_req(0, 1, 0, 5'd5, 32'h55, 32'h0);
    cycle();
    bus.req_valid = 3'b111;
    bus.wb_hold = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_eq("hold_wen", 64'(bus.rf_wen), 64'd0);
      check_eq("hold_ready", 64'(bus.req_ready), 64'd0);
      cycle();
    end
    clear_reqs();
    bus.wb_hold = 1'b0;
    #1;
    check_eq("hold_release_wen", 64'(bus.rf_wen), 64'd1);
    check_eq("hold_release_addr", 64'(bus.rf_waddr), 64'd5);
    cycle();
    #1;
    check_eq("hold_once", 64'(bus.rf_wen), 64'd0);
    cycle();

`ifdef WB_SCOREBOARD_EN
    apply_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cycle();
    cycle();
    bus.iss_valid = 1'b0;
    check_eq("sb_busy_set", 64'(bus.rd_busy[7]), 64'd1);
    set_req(0, 1, 0, 5'd7, 32'h7, 32'h0);
    cycle();
    cycle();
    clear_reqs();
    cycle();
    check_eq("sb_busy_clr", 64'(bus.rd_busy[7]), 64'd0);
    bus.iss_valid = 1'b1;
    cycle();
    bus.iss_valid = 1'b0;
    set_req(0, 1, 0, 5'd7, 32'h77, 32'h0);
    cycle();
    clear_reqs();
    bus.iss_valid = 1'b1;
    cycle();
    bus.iss_valid = 1'b0;
    check_eq("sb_same_cycle", 64'(bus.rd_busy[7]), 64'd1);
    cycle();
`endif

    // Random traffic with occasional hold and reset.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom);
      end
      bus.wb_hold = ($urandom_range(0, 4) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
`ifdef WB_SCOREBOARD_EN
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd = 5'($urandom_range(0, 31));
`endif
      cycle();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
